// File: rtl/ripple_counter4_pkg.sv
// Shared constants for the ripple_counter4 toggle-chain counter.
package ripple_counter4_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 4;
  localparam int COUNT_RESET           = 0;

endpackage : ripple_counter4_pkg

// File: rtl/ripple_counter4_if.sv
// Bundles the counter's reset request and count value for whoever drives or observes it.
interface ripple_counter4_if
  import ripple_counter4_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input logic clk
);

  logic             reset;
  logic [WIDTH-1:0] q;

  // master drives reset and consumes the count; slave is the counter side
  modport master (input clk, output reset, input q);
  modport slave  (input clk, input reset, output q);

endinterface : ripple_counter4_if

// File: rtl/ripple_counter4_tff_stage.sv
// One-bit toggle flip-flop with synchronous active-high clear.
module tff_stage
  import ripple_counter4_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic bit_d;
  logic bit_q;

  always_comb begin
    bit_d = bit_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q <= RESET_VAL;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule : tff_stage

// File: rtl/ripple_counter4.sv
// Binary up-counter: a chain of toggle stages, all on one clock, where each
// stage toggles once every lower stage reads 1.
module ripple_counter4
  import ripple_counter4_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             reset
);

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(COUNT_RESET);

  logic [WIDTH-1:0] stage_q;

  // Each generate block holds its own enable so the AND chain stays a
  // simple cascade of scalars rather than a self-referencing vector.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    logic t;

    if (gi == 0) begin : g_lsb
      assign t = 1'b1;
    end else begin : g_upper
      assign t = g_stage[gi-1].t & stage_q[gi-1];
    end

    tff_stage #(
      .RESET_VAL (RESET_Q[gi])
    ) u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (t),
      .q     (stage_q[gi])
    );
  end

  assign q = stage_q;

endmodule : ripple_counter4

// File: tb/tb_ripple_counter4.sv
// Self-checking bench for ripple_counter4: vector table, corner sequences and
// randomized reset traffic against an arithmetic count model.
module tb_ripple_counter4;
  import ripple_counter4_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  typedef struct {
    logic rst;
    int   exp_q;
  } vec_t;

  logic clk;
  int   checks;
  int   errors;
  int   model_q;

  ripple_counter4_if #(.WIDTH(W)) cif (.clk(clk));

  ripple_counter4 #(.WIDTH(W)) dut (
    .q     (cif.q),
    .clk   (clk),
    .reset (cif.reset)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  task automatic check(input string name, input int expv);
    checks++;
    if (cif.q !== W'(expv)) begin
      errors++;
      $display("FAIL %s: q=%0d expected %0d", name, cif.q, expv);
    end else begin
      $display("%s: reset=%0b q=%0d ok", name, cif.reset, cif.q);
    end
  endtask

  // One clock edge with the given reset; the model advances by arithmetic
  // and q is compared at the following falling edge.
  task automatic step(input logic r, input bit glitch, input string name);
    cif.reset = r;
    if (glitch) begin
      #1 cif.reset = 1'b1;
      #2 cif.reset = 1'b0;
    end
    @(posedge clk);
    model_q = cif.reset ? COUNT_RESET : (model_q + 1) % MOD;
    @(negedge clk);
    check(name, model_q);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    checks  = 0;
    errors  = 0;
    model_q = 0;
    cif.reset = 1'b1;
    @(negedge clk);

    // Reset hold, free count to 15, then wrap to 0 and 1.
    for (int i = 0; i < 2; i++) begin
      v.rst = 1'b1; v.exp_q = 0; vecs.push_back(v);
    end
    for (int i = 1; i <= 15; i++) begin
      v.rst = 1'b0; v.exp_q = i; vecs.push_back(v);
    end
    v.rst = 1'b0; v.exp_q = 0; vecs.push_back(v);
    v.rst = 1'b0; v.exp_q = 1; vecs.push_back(v);

    foreach (vecs[i]) begin
      cif.reset = vecs[i].rst;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp_q);
    end
    model_q = 1;

    // Count up to 9, then a one-edge reset mid-count.
    while (model_q != 9) step(1'b0, 1'b0, "to_nine");
    step(1'b1, 1'b0, "mid_reset");
    step(1'b0, 1'b0, "resume1");
    step(1'b0, 1'b0, "resume2");

    // 18 edges of counting after reset lands on 2, then a 3-edge reset.
    step(1'b1, 1'b0, "long_reset");
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, "long_run");
    checks++;
    if (cif.q !== W'(2)) begin
      errors++;
      $display("FAIL long_run_end: q=%0d expected 2", cif.q);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");

    // Reset pulse entirely between edges must be ignored.
    step(1'b0, 1'b0, "pre_glitch");
    step(1'b0, 1'b1, "glitch");
    step(1'b0, 1'b0, "post_glitch");

    // Random reset traffic against the model.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ripple_counter4
